// File: rtl/ps2_kbd_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package kbd_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int FRAME_DATA_BITS     = 8;
  localparam int TIMEOUT_CYCLES_DEF  = 2000;
  localparam int KBSR_READY_BIT      = 15;
endpackage

// File: rtl/ps2_kbd_rx_if.sv
// CPU-side keyboard register bus: KBDR read strobe in, KBSR/KBDR/status out.
interface ps2_kbd_rx_if;
  import kbd_pkg::*;
  logic                       kbdr_rd;
  logic                       kbsr_ready;
  logic [FRAME_DATA_BITS-1:0] kbdr_data;
  logic                       parity_err;
  logic                       frame_err;
  logic                       overrun;

  modport master (output kbdr_rd,
                  input  kbsr_ready, kbdr_data, parity_err, frame_err, overrun);
  modport slave  (input  kbdr_rd,
                  output kbsr_ready, kbdr_data, parity_err, frame_err, overrun);
endinterface

// File: rtl/ps2_kbd_rx_sync.sv
// Synchronizes the PS/2 clock and data lines and flags PS/2 clock falling edges.
module ps2_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic kbd_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall
);
  logic [STAGES-1:0] clk_ff;
  logic [STAGES-1:0] dat_ff;
  logic              clk_prev;

  // Synchronizer chains; reset to the idle-high line level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_ff   <= '1;
      dat_ff   <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[STAGES-2:0], kbd_clk};
      dat_ff   <= {dat_ff[STAGES-2:0], ps2_data};
      clk_prev <= clk_ff[STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_ff[STAGES-1];
  assign data_s = dat_ff[STAGES-1];
endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver feeding LC-3 KBSR/KBDR registers.
module ps2_kbd_rx
  import kbd_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kbd_clk,
  input  logic            ps2_data,
  ps2_kbd_rx_if.slave     bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_t                  state, state_n;
  logic                       data_s, fall;
  logic [2:0]                 bit_cnt;
  logic [FRAME_DATA_BITS-1:0] shreg;
  logic                       par_bit;
  logic [TW-1:0]              to_cnt;
  logic                       timeout, stop_edge, par_ok;

  logic                       ready_q, pe_q, fe_q, ov_q;
  logic [FRAME_DATA_BITS-1:0] data_q;

  ps2_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .kbd_clk  (kbd_clk),
    .ps2_data (ps2_data),
    .data_s   (data_s),
    .fall     (fall)
  );

  // Odd parity over the eight data bits plus the parity bit.
  assign par_ok = ^{shreg, par_bit};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state; a stalled frame aborts back to IDLE regardless of position.
  always_comb begin
    state_n   = state;
    timeout   = 1'b0;
    stop_edge = 1'b0;
    case (state)
      IDLE:   if (fall && !data_s) state_n = DATA;
      DATA:   if (fall && bit_cnt == 3'(FRAME_DATA_BITS - 1)) state_n = PARITY;
      PARITY: if (fall) state_n = STOP;
      STOP:   if (fall) begin
                state_n   = IDLE;
                stop_edge = 1'b1;
              end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      timeout = 1'b1;
    end
  end

  // Shift register, bit counter and inter-bit timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      to_cnt <= (state == IDLE || fall || timeout) ? '0 : to_cnt + TW'(1);
      if (fall) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shreg[bit_cnt] <= data_s;
            bit_cnt        <= bit_cnt + 3'd1;
          end
          PARITY: par_bit <= data_s;
          default: ;
        endcase
      end
    end
  end

  // Output registers: a read clears first, then same-cycle frame events take precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      data_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      if (bus.kbdr_rd) begin
        ready_q <= 1'b0;
        pe_q    <= 1'b0;
        fe_q    <= 1'b0;
        ov_q    <= 1'b0;
      end
      if (timeout) fe_q <= 1'b1;
      if (stop_edge) begin
        if (!data_s)                     fe_q <= 1'b1;
        else if (!par_ok)                pe_q <= 1'b1;
        else if (ready_q && !bus.kbdr_rd) ov_q <= 1'b1;
        else begin
          data_q  <= shreg;
          ready_q <= 1'b1;
        end
      end
    end
  end

  assign bus.kbsr_ready = ready_q;
  assign bus.kbdr_data  = data_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err  = fe_q;
  assign bus.overrun    = ov_q;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench: PS/2 frames driven bit by bit, outputs compared each cycle
// against a frame-level model of the keyboard registers.
module tb_ps2_kbd_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic kbd_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_kbd_rx_if bus ();

  ps2_kbd_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(2000)) dut (
    .clk      (clk),
    .rst      (rst),
    .kbd_clk  (kbd_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the register file as seen by the CPU.
  logic       m_ready = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_pe = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
  logic       chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of {ready, data, parity_err, frame_err, overrun}.
  always @(negedge clk) begin
    if (chk_en)
      chk("regs", {20'd0, bus.kbsr_ready, bus.kbdr_data, bus.parity_err, bus.frame_err, bus.overrun},
          {20'd0, m_ready, m_data, m_pe, m_fe, m_ov});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_ready = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit par_good, input bit stop_good,
                             input bit rd_same);
    if (rd_same) model_clear();
    if (!stop_good)     m_fe = 1'b1;
    else if (!par_good) m_pe = 1'b1;
    else if (m_ready)   m_ov = 1'b1;
    else begin
      m_data  = b;
      m_ready = 1'b1;
    end
  endtask

  // Sends the first nbits of a frame (11 = whole frame). Entered and left at posedge+1.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit rd_stop, input int hp, input int nbits);
    logic [10:0] bits;
    logic        p;
    p    = ~(^b) ^ bad_par;
    bits = {~bad_stop, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(hp);
      if (i == 10) chk_en = 1'b0;
      kbd_clk = 1'b0;
      if (i == 10 && rd_stop) begin
        tick(2);
        bus.kbdr_rd = 1'b1;
        tick(1);
        bus.kbdr_rd = 1'b0;
        tick(hp - 3);
      end else begin
        tick(hp);
      end
      kbd_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (nbits == 11) begin
      model_frame(b, !bad_par, !bad_stop, rd_stop);
      tick(1);
      chk_en = 1'b1;
    end
  endtask

  task automatic do_read();
    bus.kbdr_rd = 1'b1;
    tick(1);
    bus.kbdr_rd = 1'b0;
    model_clear();
    tick(2);
  endtask

  task automatic pin(input string name, input logic [7:0] dut_v, input logic [7:0] mod_v,
                     input logic [7:0] lit);
    chk({name, "_dut"}, {24'd0, dut_v}, {24'd0, lit});
    chk({name, "_model"}, {24'd0, mod_v}, {24'd0, lit});
  endtask

  initial begin
    bus.kbdr_rd = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(1);
    pin("rst_ready", {7'd0, bus.kbsr_ready}, {7'd0, m_ready}, 8'h00);
    pin("rst_data", bus.kbdr_data, m_data, 8'h00);
    pin("rst_flags", {5'd0, bus.parity_err, bus.frame_err, bus.overrun},
        {5'd0, m_pe, m_fe, m_ov}, 8'h00);
    chk_en = 1'b1;

    // Basic receive and read
    send_frame(8'h1C, 0, 0, 0, 50, 11);
    pin("t1_ready", {7'd0, bus.kbsr_ready}, {7'd0, m_ready}, 8'h01);
    pin("t1_data", bus.kbdr_data, m_data, 8'h1C);
    do_read();
    pin("t1_rd_ready", {7'd0, bus.kbsr_ready}, {7'd0, m_ready}, 8'h00);

    // Overrun
    send_frame(8'hF0, 0, 0, 0, 50, 11);
    send_frame(8'h1C, 0, 0, 0, 50, 11);
    pin("t2_data", bus.kbdr_data, m_data, 8'hF0);
    pin("t2_ov", {7'd0, bus.overrun}, {7'd0, m_ov}, 8'h01);
    do_read();
    pin("t2_rd", {6'd0, bus.kbsr_ready, bus.overrun}, {6'd0, m_ready, m_ov}, 8'h00);

    // Parity error then stop-bit error
    send_frame(8'h1C, 1, 0, 0, 50, 11);
    pin("t3_pe", {6'd0, bus.kbsr_ready, bus.parity_err}, {6'd0, m_ready, m_pe}, 8'h01);
    send_frame(8'hF0, 0, 1, 0, 50, 11);
    pin("t3_fe", {7'd0, bus.frame_err}, {7'd0, m_fe}, 8'h01);
    pin("t3_data", bus.kbdr_data, m_data, 8'hF0);
    do_read();

    // Timeout after 4 data bits
    send_frame(8'hA5, 0, 0, 0, 50, 5);
    tick(1900);
    chk_en = 1'b0;
    tick(200);
    m_fe = 1'b1;
    chk_en = 1'b1;
    tick(1);
    pin("t4_fe", {7'd0, bus.frame_err}, {7'd0, m_fe}, 8'h01);
    send_frame(8'h29, 0, 0, 0, 50, 11);
    pin("t4_data", bus.kbdr_data, m_data, 8'h29);
    do_read();

    // Read on the completing cycle with a byte pending
    send_frame(8'h1C, 0, 0, 0, 50, 11);
    send_frame(8'h5A, 0, 0, 1, 50, 11);
    pin("t5_data", bus.kbdr_data, m_data, 8'h5A);
    pin("t5_st", {6'd0, bus.kbsr_ready, bus.overrun}, {6'd0, m_ready, m_ov}, 8'h02);
    do_read();

    // Reset mid-frame
    send_frame(8'hFF, 0, 0, 0, 50, 11);
    send_frame(8'h45, 0, 0, 0, 50, 7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_data = 8'h00;
    model_clear();
    tick(1);
    pin("t6_rst", {bus.kbdr_data | {7'd0, bus.kbsr_ready}}, {m_data | {7'd0, m_ready}}, 8'h00);
    send_frame(8'h45, 0, 0, 0, 50, 11);
    pin("t6_data", bus.kbdr_data, m_data, 8'h45);
    do_read();

    // Randomized frames, errors and reads
    for (int k = 0; k < 30; k++) begin
      int e;
      e = $urandom_range(0, 9);
      send_frame(8'($urandom), e == 0, e == 1, $urandom_range(0, 5) == 0,
                 $urandom_range(8, 40), 11);
      if ($urandom_range(0, 1) == 1) do_read();
      tick($urandom_range(1, 20));
    end

    chk_en = 1'b0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard receiver sitting directly downstream of the keyboard model: it consumes the `kbd_clk`/`ps2_data` pair, deserializes 11-bit PS/2 frames, and presents each received scan code to the LC-3 memory-mapped keyboard registers (KBSR ready bit, KBDR data). It checks parity, stop bit and inter-bit timeout, and holds one byte until the CPU reads it.

## Interface
- `SYNC_STAGES`, 2: flops in each input synchronizer (min 2).
- `TIMEOUT_CYCLES`, 2000: `clk` cycles without a PS/2 falling edge mid-frame before the frame is aborted.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `kbd_clk`  in  1  PS/2 clock from keyboard, asynchronous, idles high.
- `ps2_data`  in  1  PS/2 data, asynchronous, idles high.
- `kbdr_rd`  in  1  one-cycle strobe: CPU read of KBDR.
- `kbsr_ready`  out  1  KBSR[15]: a byte is waiting in `kbdr_data`.
- `kbdr_data`  out  8  last accepted scan code.
- `parity_err`  out  1  sticky: frame dropped for bad parity.
- `frame_err`  out  1  sticky: frame dropped for stop bit 0 or timeout.
- `overrun`  out  1  sticky: complete good frame dropped because `kbsr_ready` was 1.

## Operation
- Both inputs pass through `SYNC_STAGES` flops; a falling edge = previous synced clock 1, current 0. All sampling happens only on that one-cycle edge pulse.
- Frame: start(0), D0..D7 LSB first, odd parity (ones in D0..D7 + P is odd), stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on edge with data 0 -> DATA, bit count 0. Edge with data 1 ignored (stays IDLE).
  - DATA: on edge shift data into bit[count]; after 8th bit -> PARITY.
  - PARITY: on edge capture P -> STOP.
  - STOP: on edge evaluate, always -> IDLE.
- Timeout counter resets on every edge and in IDLE; counts in DATA/PARITY/STOP. Reaching `TIMEOUT_CYCLES` -> IDLE, `frame_err` set, nothing delivered.
- Evaluation at STOP edge, priority: stop bit 0 -> `frame_err`; else parity bad -> `parity_err`; else if `kbsr_ready`=1 and no `kbdr_rd` this cycle -> `overrun`, byte discarded, `kbdr_data` unchanged; else `kbdr_data` <= byte, `kbsr_ready` <= 1.
- `kbdr_rd` clears `kbsr_ready` and all three sticky flags. Same cycle as a good frame completing: the new byte is loaded, `kbsr_ready` stays 1, no overrun, flags cleared (new flag events that cycle win over clear).
- `kbdr_rd` with `kbsr_ready`=0: clears flags only; `kbdr_data` unchanged.

## Timing
- Reset: FSM IDLE, counters 0, synchronizers all 1, `kbsr_ready`=0, `kbdr_data`=8'h00, all flags 0. Reset mid-frame discards the partial frame.
- Edge pulse occurs `SYNC_STAGES`+1 `clk` cycles after `kbd_clk` falls (3 with defaults).
- `kbsr_ready`, `kbdr_data`, flags update on the clock edge after the stop-bit edge pulse (registered outputs, no combinational path from inputs).
- `kbsr_ready` falls the cycle after `kbdr_rd`.
- Data must be stable for `SYNC_STAGES`+1 cycles around the PS/2 falling edge; PS/2 half-period must exceed `SYNC_STAGES`+2 `clk` cycles.

## Structure
- Package `kbd_pkg`: FSM state enum `rx_state_t`, `FRAME_DATA_BITS`=8, default `TIMEOUT_CYCLES`, KBSR ready bit index 15.
- Sub-module `ps2_sync`: parameterized synchronizer for both lines plus falling-edge pulse on the clock line; instantiated once.
- Top holds FSM, shift register, bit counter, timeout counter, output registers.

## Test plan
- Reset, then frame 0x1C (P=0, PS/2 half-period 50 clk) -> `kbsr_ready`=1, `kbdr_data`=8'h1C, flags 0; `kbdr_rd` -> `kbsr_ready`=0 next cycle.
- Frames 0xF0 (P=1) then 0x1C without read -> `kbdr_data` stays 8'hF0, `overrun`=1; read clears both.
- 0x1C sent with P=1 -> no `kbsr_ready`, `parity_err`=1; then stop bit forced 0 on 0xF0 -> `frame_err`=1, data unchanged.
- Clock stops after 4 data bits for 2000+ cycles -> `frame_err`=1, FSM IDLE; next clean 0x29 frame received correctly.
- `kbdr_rd` asserted on the exact cycle frame 0x5A completes with 0x1C pending -> `kbdr_data`=8'h5A, `kbsr_ready`=1, `overrun`=0.
- `rst` pulsed after 6 bits of a frame -> all outputs reset values; following 0x45 frame received correctly.
